log2_share_arbiter: RTL and testbench
=====================================

Name: log2_share_arbiter

Overview:
- Shares one instance of the 3-stage Q4.12 log2 approximation pipeline between two requesters.
- Round-robin arbitration selects one requester per cycle; the winner's operand pair is issued into the pipeline.
- A requester-ID tag travels in lockstep with the pipeline, so each result returns to the requester that issued it.
- Downstream backpressure stalls the whole pipeline through its enable input. The block sits between the softmax front-end requesters and the log2 stage.

Parameters:
- W, 16, operand/result width (Q4.12).
- LAT, 3, pipeline latency in enabled cycles; must match the log2 stage.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid_0  in  1  requester 0 has an operand pair
- req_ready_0  out  1  requester 0 pair accepted this cycle
- req_in0_0  in  W  requester 0 log operand
- req_in1_0  in  W  requester 0 bypass operand
- req_valid_1  in  1  requester 1 has an operand pair
- req_ready_1  out  1  requester 1 pair accepted this cycle
- req_in0_1  in  W  requester 1 log operand
- req_in1_1  in  W  requester 1 bypass operand
- pipe_en  out  1  log2 stage enable
- pipe_valid_in  out  1  log2 stage valid_in
- pipe_in_0  out  W  log2 stage in_0
- pipe_in_1  out  W  log2 stage in_1
- pipe_valid_out  in  1  log2 stage valid_out
- pipe_log  in  W  log2 stage log_in_0
- pipe_byp_0  in  W  log2 stage in_0_bypass
- pipe_byp_1  in  W  log2 stage in_1_bypass
- rsp_valid_0 / rsp_valid_1  out  1  result valid for requester 0 / 1
- rsp_ready_0 / rsp_ready_1  in  1  requester 0 / 1 can take its result
- rsp_log  out  W  shared result log2 value
- rsp_in0  out  W  shared result bypass of in_0
- rsp_in1  out  W  shared result bypass of in_1
- busy  out  1  at least one item in flight
- err_tag  out  1  sticky tag/valid misalignment flag

Behaviour:
- Reset (sync): rr_ptr=0 (requester 0 has priority), tag shift register all zero, in_flight=0, err_tag=0.
- During reset, pipe_en=1, pipe_valid_in=0 and req_ready_*=0 so the pipeline flushes alongside its own reset.
- Tag register: LAT entries of {tv, tid}.
  - Entry 0 loads {issue, grant_id} on every cycle with pipe_en=1; entries shift toward entry LAT-1 on the same condition.
  - With pipe_en=0, all entries hold.
- Output tag: tag_out is entry LAT-1.
  - rsp_valid_k = pipe_valid_out & tv_out & (tid_out==k).
  - rsp_log, rsp_in0, rsp_in1 are combinational pass-throughs of pipe_log, pipe_byp_0, pipe_byp_1.
- Stall: stall = pipe_valid_out & ~rsp_ready[tid_out]; pipe_en = ~stall.
  - While stalled, all pipeline and tag state holds, response outputs stay stable and req_ready_*=0.
- Arbitration (combinational):
  - Only one requester valid: that requester wins.
  - Both valid: the winner is the one rr_ptr points to.
  - issue = any winner & pipe_en; req_ready_k = issue & (winner==k).
  - pipe_valid_in = issue; pipe_in_0/pipe_in_1 are muxed from the winner, and drive 0 when there is no winner.
  - On issue, rr_ptr <= ~winner.
- Throughput: one issue per cycle; each result appears exactly LAT enabled cycles after its issue.
- in_flight counter (0..LAT):
  - +1 on issue; -1 on a response handshake (rsp_valid_k & rsp_ready_k); both in the same cycle means no change.
  - busy = (in_flight != 0).
  - Never exceeds LAT, because a stall blocks issue.
- err_tag: set when pipe_valid_out != tv_out on any pipe_en=1 cycle; cleared only by reset.
- Zero operand: passed through unchecked; the log value is don't-care.
- Reset mid-operation: all in-flight items are dropped, no rsp_valid is asserted after reset, and rr_ptr returns to 0.

Test Plan:
- Requester 0 only, in0=0x1000 (1.0), in1=0xABCD:
  - accepted cycle 0, rsp_valid_0=1 at cycle 3;
  - rsp_log=0x0000, rsp_in0=0x1000, rsp_in1=0xABCD;
  - busy 1 during cycles 1-3.
- Both requesters continuously valid for 6 cycles, rsp_ready=1:
  - grants alternate 0,1,0,1,0,1;
  - responses alternate at cycles 3-8 with matching bypass data;
  - err_tag stays 0.
- Requester 1 alone, back-to-back for 4 items, in0=0x2000,0x4000,0x0800,0x8000:
  - 4 consecutive rsp_valid_1 cycles;
  - rsp_log=0x1000, 0x2000, 0xF000, 0x3000.
- Backpressure: rsp_ready_0=0 for 5 cycles while its result is at the output:
  - pipe_en=0, req_ready_*=0, outputs held stable;
  - on release, the result is consumed and issue resumes next cycle with no loss or duplication.
- Reset asserted 2 cycles after 2 issues:
  - no rsp_valid for 5 cycles after reset;
  - busy=0, next simultaneous request granted to requester 0.
- Forced misalignment (pipe_valid_out driven high while tv_out=0):
  - err_tag rises next cycle and stays set until rst.

Source files
------------

// File: rtl/log2_share_arbiter_if.sv
// Bus bundle between the two softmax requesters, the shared log2 pipeline
// and the result consumers.
//   slave  : arbiter side (takes requests and pipeline results, drives
//            grants, pipeline inputs and responses)
//   master : environment side (requesters, log2 stage, result consumers)
interface log2_share_arbiter_if #(
  parameter int unsigned W = 16
);
  // Requester 0
  logic         req_valid_0;
  logic         req_ready_0;
  logic [W-1:0] req_in0_0;
  logic [W-1:0] req_in1_0;
  // Requester 1
  logic         req_valid_1;
  logic         req_ready_1;
  logic [W-1:0] req_in0_1;
  logic [W-1:0] req_in1_1;
  // Shared log2 stage
  logic         pipe_en;
  logic         pipe_valid_in;
  logic [W-1:0] pipe_in_0;
  logic [W-1:0] pipe_in_1;
  logic         pipe_valid_out;
  logic [W-1:0] pipe_log;
  logic [W-1:0] pipe_byp_0;
  logic [W-1:0] pipe_byp_1;
  // Responses
  logic         rsp_valid_0;
  logic         rsp_valid_1;
  logic         rsp_ready_0;
  logic         rsp_ready_1;
  logic [W-1:0] rsp_log;
  logic [W-1:0] rsp_in0;
  logic [W-1:0] rsp_in1;
  // Status
  logic         busy;
  logic         err_tag;

  modport slave (
    input  req_valid_0, req_in0_0, req_in1_0,
    input  req_valid_1, req_in0_1, req_in1_1,
    output req_ready_0, req_ready_1,
    output pipe_en, pipe_valid_in, pipe_in_0, pipe_in_1,
    input  pipe_valid_out, pipe_log, pipe_byp_0, pipe_byp_1,
    output rsp_valid_0, rsp_valid_1, rsp_log, rsp_in0, rsp_in1,
    input  rsp_ready_0, rsp_ready_1,
    output busy, err_tag
  );

  modport master (
    output req_valid_0, req_in0_0, req_in1_0,
    output req_valid_1, req_in0_1, req_in1_1,
    input  req_ready_0, req_ready_1,
    input  pipe_en, pipe_valid_in, pipe_in_0, pipe_in_1,
    output pipe_valid_out, pipe_log, pipe_byp_0, pipe_byp_1,
    input  rsp_valid_0, rsp_valid_1, rsp_log, rsp_in0, rsp_in1,
    output rsp_ready_0, rsp_ready_1,
    input  busy, err_tag
  );
endinterface

// File: rtl/log2_share_arbiter.sv
// Shares one LAT-deep log2 pipeline between two requesters. A round-robin
// arbiter issues one operand pair per cycle; a {valid, id} tag shifts in
// lockstep with the pipeline so each result is steered back to its issuer.
// A result its owner cannot take stalls the whole pipeline via pipe_en.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : log2_share_arbiter_if.slave (requests, pipeline, responses,
//              busy and sticky err_tag status)
module log2_share_arbiter #(
  parameter int unsigned W   = 16,
  parameter int unsigned LAT = 3
) (
  input logic                 clk,
  input logic                 rst,
  log2_share_arbiter_if.slave bus
);
  localparam int unsigned CntW = $clog2(LAT + 1);

  logic [LAT-1:0]  tv_q, tv_d;
  logic [LAT-1:0]  tid_q, tid_d;
  logic            rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0] in_flight_q, in_flight_d;
  logic            err_tag_q, err_tag_d;

  logic         tv_out, tid_out;
  logic         sel_ready, stall, pipe_en;
  logic         any_req, winner, issue;
  logic         rsp_valid_0, rsp_valid_1, rsp_hs;
  logic [W-1:0] sel_in0, sel_in1;

  assign tv_out  = tv_q[LAT-1];
  assign tid_out = tid_q[LAT-1];

  always_comb begin
    sel_ready = tid_out ? bus.rsp_ready_1 : bus.rsp_ready_0;
    stall     = bus.pipe_valid_out & ~sel_ready;
    // Keep the pipeline clocking during reset so it flushes with us.
    pipe_en   = rst | ~stall;

    any_req = bus.req_valid_0 | bus.req_valid_1;
    if (bus.req_valid_0 && bus.req_valid_1) begin
      winner = rr_ptr_q;
    end else begin
      winner = bus.req_valid_1;
    end
    issue = any_req & pipe_en & ~rst;

    sel_in0 = '0;
    sel_in1 = '0;
    if (any_req) begin
      sel_in0 = winner ? bus.req_in0_1 : bus.req_in0_0;
      sel_in1 = winner ? bus.req_in1_1 : bus.req_in1_0;
    end

    rsp_valid_0 = bus.pipe_valid_out & tv_out & ~tid_out;
    rsp_valid_1 = bus.pipe_valid_out & tv_out & tid_out;
    rsp_hs      = (rsp_valid_0 & bus.rsp_ready_0) | (rsp_valid_1 & bus.rsp_ready_1);
  end

  always_comb begin
    tv_d        = tv_q;
    tid_d       = tid_q;
    rr_ptr_d    = rr_ptr_q;
    in_flight_d = in_flight_q + CntW'(issue) - CntW'(rsp_hs);
    err_tag_d   = err_tag_q;
    if (pipe_en) begin
      for (int unsigned i = 1; i < LAT; i++) begin
        tv_d[i]  = tv_q[i-1];
        tid_d[i] = tid_q[i-1];
      end
      tv_d[0]  = issue;
      tid_d[0] = winner;
      // A valid result without a matching tag (or vice versa) means the
      // pipeline and the tag chain have drifted apart.
      if (bus.pipe_valid_out != tv_out) begin
        err_tag_d = 1'b1;
      end
    end
    if (issue) begin
      rr_ptr_d = ~winner;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tv_q        <= '0;
      tid_q       <= '0;
      rr_ptr_q    <= 1'b0;
      in_flight_q <= '0;
      err_tag_q   <= 1'b0;
    end else begin
      tv_q        <= tv_d;
      tid_q       <= tid_d;
      rr_ptr_q    <= rr_ptr_d;
      in_flight_q <= in_flight_d;
      err_tag_q   <= err_tag_d;
    end
  end

  assign bus.req_ready_0   = issue & ~winner;
  assign bus.req_ready_1   = issue & winner;
  assign bus.pipe_en       = pipe_en;
  assign bus.pipe_valid_in = issue;
  assign bus.pipe_in_0     = sel_in0;
  assign bus.pipe_in_1     = sel_in1;
  assign bus.rsp_valid_0   = rsp_valid_0;
  assign bus.rsp_valid_1   = rsp_valid_1;
  assign bus.rsp_log       = bus.pipe_log;
  assign bus.rsp_in0       = bus.pipe_byp_0;
  assign bus.rsp_in1       = bus.pipe_byp_1;
  assign bus.busy          = (in_flight_q != '0);
  assign bus.err_tag       = err_tag_q;
endmodule

// File: tb/tb_log2_share_arbiter.sv
module tb_log2_share_arbiter;
  localparam int unsigned LAT = 3;

  typedef struct packed {
    logic        id;
    logic [15:0] in0;
    logic [15:0] in1;
    logic [15:0] lg;
    logic [3:0]  age;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_vo = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  log2_share_arbiter_if #(.W(16)) bus ();

  log2_share_arbiter #(.W(16), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Q4.12 log2: integer part from the leading one, linear fraction.
  function automatic logic [15:0] log2_ref(input logic [15:0] x);
    int p;
    logic [15:0] f;
    if (x == 16'h0) return 16'h0;
    p = 15;
    while (!x[p]) p--;
    f = x << (15 - p);
    return 16'((p - 12) * 4096) + {4'h0, f[14:3]};
  endfunction

  // Stand-in for the shared log2 stage.
  logic [LAT-1:0] pv = '0;
  logic [15:0]    pl [LAT];
  logic [15:0]    pb0[LAT];
  logic [15:0]    pb1[LAT];
  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
    end else if (bus.pipe_en) begin
      pv     <= {pv[LAT-2:0], bus.pipe_valid_in};
      pl[0]  <= log2_ref(bus.pipe_in_0);
      pb0[0] <= bus.pipe_in_0;
      pb1[0] <= bus.pipe_in_1;
      for (int i = 1; i < LAT; i++) begin
        pl[i]  <= pl[i-1];
        pb0[i] <= pb0[i-1];
        pb1[i] <= pb1[i-1];
      end
    end
  end
  assign bus.pipe_valid_out = pv[LAT-1] | force_vo;
  assign bus.pipe_log       = pl[LAT-1];
  assign bus.pipe_byp_0     = pb0[LAT-1];
  assign bus.pipe_byp_1     = pb1[LAT-1];

  // Reference model: in-flight items with the number of enabled cycles since issue.
  item_t mq[$];
  item_t seen[$];
  logic  gq[$];
  logic  m_rr = 1'b0;
  logic  m_err = 1'b0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v0, input logic [15:0] a0, input logic [15:0] b0,
                      input logic v1, input logic [15:0] a1, input logic [15:0] b1,
                      input logic r0, input logic r1, input logic rs, input logic fv);
    logic present, hid, pvo, hready, exp_en, win, exp_iss;
    bus.req_valid_0 = v0; bus.req_in0_0 = a0; bus.req_in1_0 = b0;
    bus.req_valid_1 = v1; bus.req_in0_1 = a1; bus.req_in1_1 = b1;
    bus.rsp_ready_0 = r0; bus.rsp_ready_1 = r1;
    rst = rs; force_vo = fv;
    @(negedge clk);
    present = (mq.size() > 0) && (mq[0].age == 4'(LAT));
    hid     = present ? mq[0].id : 1'b0;
    pvo     = present | fv;
    hready  = hid ? r1 : r0;
    exp_en  = rs | ~(pvo & ~hready);
    win     = (v0 && v1) ? m_rr : v1;
    exp_iss = (v0 | v1) & exp_en & ~rs;
    chk("pipe_en", 16'(bus.pipe_en), 16'(exp_en));
    chk("pipe_valid_in", 16'(bus.pipe_valid_in), 16'(exp_iss));
    chk("req_ready_0", 16'(bus.req_ready_0), 16'(exp_iss & ~win));
    chk("req_ready_1", 16'(bus.req_ready_1), 16'(exp_iss & win));
    if (exp_iss) begin
      chk("pipe_in_0", bus.pipe_in_0, win ? a1 : a0);
      chk("pipe_in_1", bus.pipe_in_1, win ? b1 : b0);
    end else if (!(v0 || v1)) begin
      chk("pipe_in_0_idle", bus.pipe_in_0, 16'h0);
    end
    chk("rsp_valid_0", 16'(bus.rsp_valid_0), 16'(present & ~hid));
    chk("rsp_valid_1", 16'(bus.rsp_valid_1), 16'(present & hid));
    if (present) begin
      chk("rsp_log", bus.rsp_log, mq[0].lg);
      chk("rsp_in0", bus.rsp_in0, mq[0].in0);
      chk("rsp_in1", bus.rsp_in1, mq[0].in1);
    end
    chk("busy", 16'(bus.busy), 16'(mq.size() != 0));
    chk("err_tag", 16'(bus.err_tag), 16'(m_err));
    if ((bus.rsp_valid_0 && r0) || (bus.rsp_valid_1 && r1))
      seen.push_back('{id: bus.rsp_valid_1, in0: bus.rsp_in0, in1: bus.rsp_in1,
                       lg: bus.rsp_log, age: 4'd0});
    if (bus.req_ready_0) gq.push_back(1'b0);
    if (bus.req_ready_1) gq.push_back(1'b1);
    @(posedge clk);
    if (rs) begin
      mq.delete();
      m_rr  = 1'b0;
      m_err = 1'b0;
    end else if (exp_en) begin
      if (pvo != present) m_err = 1'b1;
      if (present && hready) void'(mq.pop_front());
      for (int i = 0; i < mq.size(); i++) mq[i].age = mq[i].age + 4'd1;
      if (exp_iss) begin
        mq.push_back('{id: win, in0: win ? a1 : a0, in1: win ? b1 : b0,
                       lg: log2_ref(win ? a1 : a0), age: 4'd1});
        m_rr = ~win;
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input logic r0, input logic r1);
    for (int i = 0; i < n; i++) step(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, r0, r1, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 16'h1111, 16'h2222, 1, 16'h3333, 16'h4444, 1, 1, 1, 0);
    seen.delete();
    gq.delete();
  endtask

  initial begin
    logic [15:0] s3_in [4];
    logic [15:0] s3_log[4];
    s3_in  = '{16'h2000, 16'h4000, 16'h0800, 16'h8000};
    s3_log = '{16'h1000, 16'h2000, 16'hF000, 16'h3000};
    bus.req_valid_0 = 0; bus.req_in0_0 = 0; bus.req_in1_0 = 0;
    bus.req_valid_1 = 0; bus.req_in0_1 = 0; bus.req_in1_1 = 0;
    bus.rsp_ready_0 = 1; bus.rsp_ready_1 = 1;
    repeat (2) @(posedge clk);
    #1;

    // Single request from requester 0.
    do_reset();
    step(1, 16'h1000, 16'hABCD, 0, 16'h0, 16'h0, 1, 1, 0, 0);
    idle(5, 1, 1);
    chk("s1_count", 16'(seen.size()), 16'd1);
    if (seen.size() >= 1) begin
      chk("s1_id", 16'(seen[0].id), 16'd0);
      chk("s1_log", seen[0].lg, 16'h0000);
      chk("s1_in0", seen[0].in0, 16'h1000);
      chk("s1_in1", seen[0].in1, 16'hABCD);
    end

    // Both requesters contending for 6 cycles.
    do_reset();
    for (int i = 0; i < 6; i++)
      step(1, 16'h1000 + 16'(i), 16'hA000 + 16'(i), 1, 16'h2000 + 16'(i), 16'hB000 + 16'(i),
           1, 1, 0, 0);
    idle(5, 1, 1);
    chk("s2_grants", 16'(gq.size()), 16'd6);
    for (int i = 0; i < gq.size(); i++) chk("s2_grant_order", 16'(gq[i]), 16'(i % 2));
    chk("s2_rsps", 16'(seen.size()), 16'd6);
    for (int i = 0; i < seen.size(); i++) chk("s2_rsp_order", 16'(seen[i].id), 16'(i % 2));

    // Requester 1 back-to-back.
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 16'h0, 16'h0, 1, s3_in[i], 16'(i), 1, 1, 0, 0);
    idle(5, 1, 1);
    chk("s3_count", 16'(seen.size()), 16'd4);
    for (int i = 0; i < seen.size(); i++) chk("s3_log", seen[i].lg, s3_log[i]);

    // Backpressure on requester 0's result.
    do_reset();
    step(1, 16'h1234, 16'h5678, 0, 16'h0, 16'h0, 1, 1, 0, 0);
    idle(2, 1, 1);
    for (int i = 0; i < 5; i++) step(1, 16'h0C00, 16'h1, 1, 16'h0E00, 16'h2, 0, 1, 0, 0);
    chk("s4_held", 16'(seen.size()), 16'd0);
    step(1, 16'h0C00, 16'h1, 1, 16'h0E00, 16'h2, 1, 1, 0, 0);
    chk("s4_release", 16'(seen.size()), 16'd1);
    idle(5, 1, 1);
    chk("s4_total", 16'(seen.size()), 16'd2);

    // Reset with items in flight.
    do_reset();
    step(1, 16'h1000, 16'h1, 1, 16'h2000, 16'h2, 0, 0, 0, 0);
    step(1, 16'h1000, 16'h1, 1, 16'h2000, 16'h2, 0, 0, 0, 0);
    idle(2, 0, 0);
    do_reset();
    idle(5, 1, 1);
    chk("s5_no_rsp", 16'(seen.size()), 16'd0);
    step(1, 16'h1000, 16'h1, 1, 16'h2000, 16'h2, 1, 1, 0, 0);
    chk("s5_grant0", 16'(gq.size() == 1 && gq[0] == 1'b0), 16'd1);
    idle(5, 1, 1);

    // Forced misalignment: valid_out with no tag.
    do_reset();
    idle(2, 1, 1);
    step(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1, 1, 0, 1);
    idle(4, 1, 1);
    do_reset();
    idle(2, 1, 1);

    // Random traffic.
    for (int i = 0; i < 500; i++)
      step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
           1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
           1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 99) == 0), 1'b0);
    idle(8, 1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
